// File: rtl/vga_sprite_bounce.sv
// Bouncing sprite stage: moves a W x H ROM sprite once per frame, renders it.
// Optional colour-key transparency enabled by VGA_SPRITE_TRANSPARENT_EN.
module vga_sprite_bounce #(
    parameter int HBP      = 144,
    parameter int VBP      = 31,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int W        = 240,
    parameter int H        = 160,
    parameter int ADDR_W   = 16,
    parameter int CW       = 4,
    parameter int ROM_LAT  = 1,
    parameter int DX       = 1,
    parameter int DY       = 1,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter logic [3*CW-1:0] BG = '0
`ifdef VGA_SPRITE_TRANSPARENT_EN
    ,
    parameter logic [3*CW-1:0] KEY = (3*CW)'(12'h0F0)
`endif
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vidon,
    input  logic [10:0]       hc,
    input  logic [10:0]       vc,
    input  logic              pause,
    input  logic [3*CW-1:0]   rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue
);

    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - W);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - H);
    localparam logic [10:0] STEP_X = 11'(DX);
    localparam logic [10:0] STEP_Y = 11'(DY);

    generate
        if (W > H_ACTIVE || H > V_ACTIVE) begin : g_bad_size
            $error("vga_sprite_bounce: sprite larger than visible area");
        end
        if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_lat
            $error("vga_sprite_bounce: ROM_LAT must be 1..3");
        end
        if (W * H > (1 << ADDR_W)) begin : g_bad_addr
            $error("vga_sprite_bounce: W*H exceeds ROM address space");
        end
    endgenerate

    logic [9:0]          r_pos_x, r_pos_y;
    logic                r_dir_x, r_dir_y;
    logic [ROM_LAT-1:0]  r_spr_d, r_vid_d;
    logic [3*CW-1:0]     r_rgb;

    logic [10:0]         w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic [10:0]         w_xpix, w_ypix;
    logic                w_spr_on, w_tick, w_opaque;
    logic [ADDR_W-1:0]   w_addr;
    logic [10:0]         w_sum_x, w_sum_y;
    logic [9:0]          w_nx, w_ny;
    logic                w_ndx, w_ndy;

    // Sprite window in counter coordinates; all sums fit in 11 bits
    assign w_x_lo   = 11'(HBP) + {1'b0, r_pos_x};
    assign w_x_hi   = w_x_lo + 11'(W);
    assign w_y_lo   = 11'(VBP) + {1'b0, r_pos_y};
    assign w_y_hi   = w_y_lo + 11'(H);
    assign w_spr_on = (hc >= w_x_lo) && (hc < w_x_hi) &&
                      (vc >= w_y_lo) && (vc < w_y_hi);

    assign w_xpix   = hc - w_x_lo;
    assign w_ypix   = vc - w_y_lo;
    assign w_addr   = ADDR_W'(w_ypix) * ADDR_W'(W) + ADDR_W'(w_xpix);
    assign rom_addr = w_spr_on ? w_addr : '0;

    assign w_tick   = (hc == 11'd0) && (vc == 11'(VBP + V_ACTIVE));

`ifdef VGA_SPRITE_TRANSPARENT_EN
    assign w_opaque = (rom_data != KEY);
`else
    assign w_opaque = 1'b1;
`endif

    always_comb begin
        w_nx    = r_pos_x;
        w_ny    = r_pos_y;
        w_ndx   = r_dir_x;
        w_ndy   = r_dir_y;
        w_sum_x = {1'b0, r_pos_x} + STEP_X;
        w_sum_y = {1'b0, r_pos_y} + STEP_Y;
        if (r_dir_x) begin
            if (w_sum_x >= XMAX) begin
                w_nx  = XMAX[9:0];
                w_ndx = 1'b0;
            end else begin
                w_nx  = w_sum_x[9:0];
            end
        end else if ({1'b0, r_pos_x} <= STEP_X) begin
            w_nx  = '0;
            w_ndx = 1'b1;
        end else begin
            w_nx  = r_pos_x - STEP_X[9:0];
        end
        if (r_dir_y) begin
            if (w_sum_y >= YMAX) begin
                w_ny  = YMAX[9:0];
                w_ndy = 1'b0;
            end else begin
                w_ny  = w_sum_y[9:0];
            end
        end else if ({1'b0, r_pos_y} <= STEP_Y) begin
            w_ny  = '0;
            w_ndy = 1'b1;
        end else begin
            w_ny  = r_pos_y - STEP_Y[9:0];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pos_x <= 10'(X0);
            r_pos_y <= 10'(Y0);
            r_dir_x <= 1'b1;
            r_dir_y <= 1'b1;
        end else if (w_tick && !pause) begin
            r_pos_x <= w_nx;
            r_pos_y <= w_ny;
            r_dir_x <= w_ndx;
            r_dir_y <= w_ndy;
        end
    end

    // Region/blanking flags travel alongside the ROM read
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_spr_d <= '0;
            r_vid_d <= '0;
        end else begin
            r_spr_d[0] <= w_spr_on;
            r_vid_d[0] <= vidon;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_spr_d[i] <= r_spr_d[i-1];
                r_vid_d[i] <= r_vid_d[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rgb <= '0;
        end else if (r_vid_d[ROM_LAT-1] && r_spr_d[ROM_LAT-1] && w_opaque) begin
            r_rgb <= rom_data;
        end else if (r_vid_d[ROM_LAT-1]) begin
            r_rgb <= BG;
        end else begin
            r_rgb <= '0;
        end
    end

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;
    assign red   = r_rgb[3*CW-1:2*CW];
    assign green = r_rgb[2*CW-1:CW];
    assign blue  = r_rgb[CW-1:0];

endmodule

// File: tb/tb_vga_sprite_bounce.sv
// Directed bench for vga_sprite_bounce: addressing, latency, blanking,
// bounce, pause, async reset and the colour key.
module tb_vga_sprite_bounce;

    logic        clk;
    logic        clr;
    logic        vidon;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        pause;
    logic        p2;
    logic [11:0] rom_val;
    logic [11:0] rom_q;

    logic [15:0] a_addr, b_addr, c_addr;
    logic [9:0]  a_px, a_py, b_px, b_py, c_px, c_py;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    int n_chk;
    int n_err;

    vga_sprite_bounce #(.BG(12'h123)) u_dut (
        .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc),
        .pause(pause), .rom_data(rom_q), .rom_addr(a_addr),
        .pos_x(a_px), .pos_y(a_py), .red(a_r), .green(a_g), .blue(a_b)
    );

    vga_sprite_bounce #(.X0(399), .Y0(319)) u_bnc (
        .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc),
        .pause(p2), .rom_data(rom_q), .rom_addr(b_addr),
        .pos_x(b_px), .pos_y(b_py), .red(b_r), .green(b_g), .blue(b_b)
    );

    vga_sprite_bounce #(.W(241), .X0(397), .DX(2)) u_low (
        .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc),
        .pause(p2), .rom_data(rom_q), .rom_addr(c_addr),
        .pos_x(c_px), .pos_y(c_py), .red(c_r), .green(c_g), .blue(c_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle ROM model returning a programmable value
    always @(posedge clk) rom_q <= rom_val;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic vid);
        hc    = 11'(h);
        vc    = 11'(v);
        vidon = vid;
    endtask

    task automatic tick();
        hc = 11'd0;
        vc = 11'd511;
        step();
        hc = 11'd0;
        vc = 11'd0;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        clr     = 1'b1;
        vidon   = 1'b0;
        hc      = '0;
        vc      = '0;
        pause   = 1'b0;
        p2      = 1'b1;
        rom_val = '0;
        step();
        step();

        check("rst_rgb", {20'd0, a_r, a_g, a_b}, 32'h0);
        check("rst_pos", {12'd0, a_px, a_py}, {12'd0, 10'd0, 10'd0});
        check("rst_bnc", {12'd0, b_px, b_py}, {12'd0, 10'd399, 10'd319});
        clr = 1'b0;

        pix(144, 31, 1'b0);
        #1 check("addr_first", 32'(a_addr), 32'd0);
        pix(144 + 239, 31 + 159, 1'b0);
        #1 check("addr_last", 32'(a_addr), 32'd38399);
        pix(154, 33, 1'b0);
        #1 check("addr_mid", 32'(a_addr), 32'd490);
        pix(144 + 240, 31, 1'b0);
        #1 check("addr_out", 32'(a_addr), 32'd0);

        rom_val = 12'hABC;
        pix(144 + 240, 31, 1'b1);
        step(); step(); step();
        check("bg_right", {20'd0, a_r, a_g, a_b}, 32'h123);
        pix(150, 40, 1'b1);
        step();
        check("lat_1clk", {20'd0, a_r, a_g, a_b}, 32'h123);
        step();
        check("lat_2clk", {20'd0, a_r, a_g, a_b}, 32'hABC);

        pix(150, 40, 1'b0);
        step(); step();
        check("blank_in", {20'd0, a_r, a_g, a_b}, 32'h0);
        pix(150, 31 + 160, 1'b1);
        step(); step();
        check("bg_below", {20'd0, a_r, a_g, a_b}, 32'h123);

        pause = 1'b1;
        tick(); tick(); tick();
        check("pause_pos", {12'd0, a_px, a_py}, {12'd0, 10'd0, 10'd0});
        pause = 1'b0;
        tick();
        check("unpause", {12'd0, a_px, a_py}, {12'd0, 10'd1, 10'd1});

        pause = 1'b1;
        p2    = 1'b0;
        tick();
        check("bnc_hit", {12'd0, b_px, b_py}, {12'd0, 10'd400, 10'd320});
        check("low_hit", 32'(c_px), 32'd399);
        tick();
        check("bnc_back", {12'd0, b_px, b_py}, {12'd0, 10'd399, 10'd319});
        check("low_back", 32'(c_px), 32'd397);
        for (int i = 0; i < 198; i++) tick();
        check("low_at1", 32'(c_px), 32'd1);
        tick();
        check("low_zero", 32'(c_px), 32'd0);
        tick();
        check("low_up", 32'(c_px), 32'd2);
        p2 = 1'b1;

        check("held_pos", {12'd0, a_px, a_py}, {12'd0, 10'd1, 10'd1});
        rom_val = 12'hABC;
        pix(200, 100, 1'b1);
        step(); step();
        check("pre_clr", {20'd0, a_r, a_g, a_b}, 32'hABC);
        #2 clr = 1'b1;
        #1;
        check("clr_rgb", {20'd0, a_r, a_g, a_b}, 32'h0);
        check("clr_pos", {12'd0, a_px, a_py}, {12'd0, 10'd0, 10'd0});
        step();
        clr = 1'b0;
        step();
        check("rel_1clk", {20'd0, a_r, a_g, a_b}, 32'h0);
        step();
        check("rel_2clk", {20'd0, a_r, a_g, a_b}, 32'hABC);

        rom_val = 12'h0F0;
        step(); step();
`ifdef VGA_SPRITE_TRANSPARENT_EN
        check("key_px", {20'd0, a_r, a_g, a_b}, 32'h123);
`else
        check("key_px", {20'd0, a_r, a_g, a_b}, 32'h0F0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sprite_bounce.md
Name: vga_sprite_bounce

Overview:
- Parametrised successor to the fixed 240x160 screensaver sprite stage.
- Owns the sprite position and moves it once per frame, bouncing off the visible-area edges.
- Generates the sprite ROM address and realigns colour output for a ROM read latency of ROM_LAT cycles.
- Sits between the vga_640x480 timing generator (hc, vc, vidon) and the RGB pins, with a block-ROM sprite image.

Parameters:
- HBP, 144, first visible hc value.
- VBP, 31, first visible vc value.
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in lines.
- W, 240, sprite width in pixels.
- H, 160, sprite height in lines.
- ADDR_W, 16, ROM address width; W*H must be <= 2^ADDR_W.
- CW, 4, bits per colour channel.
- ROM_LAT, 1, ROM read latency in clk cycles; legal range 1..3.
- DX, 1, horizontal step per frame in pixels.
- DY, 1, vertical step per frame in lines.
- X0, 0, reset x position.
- Y0, 0, reset y position.
- BG, 0, background colour {r,g,b}, 3*CW bits.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- clr  in  1  asynchronous active-high reset.
- vidon  in  1  visible-area flag from the timing generator.
- hc  in  11  horizontal counter.
- vc  in  11  vertical counter.
- pause  in  1  when high, position is frozen.
- rom_data  in  3*CW  sprite pixel {r,g,b}, valid ROM_LAT clocks after rom_addr.
- rom_addr  out  ADDR_W  sprite ROM address.
- pos_x  out  10  current sprite x, relative to the visible area.
- pos_y  out  10  current sprite y.
- red  out  CW  colour output.
- green  out  CW  colour output.
- blue  out  CW  colour output.

Behaviour:
- Reset (clr high, asynchronous):
  - pos_x=X0, pos_y=Y0, dir_x=+, dir_y=+.
  - All pipeline stages cleared to 0; red/green/blue=0.
  - rom_addr is combinational and needs no reset value.
- Sprite region: spr_on = (hc >= HBP+pos_x) && (hc < HBP+pos_x+W) && (vc >= VBP+pos_y) && (vc < VBP+pos_y+H).
- Address:
  - xpix = hc-HBP-pos_x; ypix = vc-VBP-pos_y.
  - rom_addr = ypix*W + xpix, truncated to ADDR_W.
  - rom_addr is combinational from hc, vc, pos_x and pos_y.
  - When spr_on=0, rom_addr=0.
- Latency alignment:
  - spr_on and vidon are delayed through ROM_LAT registers.
  - Output register, on each clk: if vidon_d && spr_on_d then {red,green,blue}=rom_data, else BG when vidon_d, else 0.
  - Total latency from hc/vc to pins is ROM_LAT+1 clocks. The timing generator delays hsync/vsync by the same amount; that is not this block's job.
- Frame tick:
  - One-clock internal pulse when hc==0 && vc==VBP+V_ACTIVE (start of vertical blanking).
  - Position updates only on this pulse, so there is no tearing.
- Motion, on tick when pause=0, with XMAX=H_ACTIVE-W and YMAX=V_ACTIVE-H:
  - dir_x=+: if pos_x+DX >= XMAX then pos_x=XMAX, dir_x=-; else pos_x+=DX.
  - dir_x=-: if pos_x <= DX then pos_x=0, dir_x=+; else pos_x-=DX.
  - Y axis follows the same rule with DY and YMAX.
  - Both axes update in the same tick. A corner hit flips both directions.
- pause=1 on a tick: position and directions hold. Rendering continues.
- Arithmetic: compare sums computed in 11 bits; no wrap is permitted.
- clr mid-frame: outputs go to 0 immediately. Rendering resumes on the next clk after release, at position X0,Y0.
- Elaboration error (generate-time $error) if W>H_ACTIVE, H>V_ACTIVE, or ROM_LAT is outside 1..3.

Optional Feature:
- Macro: VGA_SPRITE_TRANSPARENT_EN.
- When defined: adds parameter KEY (3*CW bits, default 12'h0F0). A sprite pixel whose rom_data==KEY renders as BG, i.e. it is transparent.
- When undefined: KEY does not exist and every sprite pixel is drawn as read from the ROM.

Test Plan:
1. Reset with X0=0, Y0=0; release clr; drive hc=144, vc=31 -> rom_addr=0. Drive hc=144+239, vc=31+159 -> rom_addr=38399.
2. ROM_LAT=1, ROM model returns 12'hABC, in-sprite visible pixel -> red=A, green=B, blue=C exactly 2 clocks after hc/vc is applied. Pixel at hc=144+240 -> BG.
3. vidon=0 inside the sprite region -> RGB=0. vidon=1 outside the sprite -> BG.
4. X0=399, DX=1 -> after 1 tick pos_x=400 and dir flips; after the next tick pos_x=399. X0=1 with dir -, DX=2 -> pos_x=0 and dir becomes +.
5. pause=1 over 3 frame ticks -> pos_x/pos_y unchanged. Release pause -> the next tick moves by DX/DY.
6. Assert clr mid-line inside the sprite -> RGB=0 in the same cycle; pos resets to X0,Y0. With VGA_SPRITE_TRANSPARENT_EN, rom_data=12'h0F0 -> BG output.
